// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the syncram port arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - winner select between fetch and data requesters
// MEM_ARB_RR_EN builds a round-robin pointer; otherwise data has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req_i,
  input  logic d_req_i,
  input  logic grant_en_i,
  output logic any_req_o,
  output logic win_o
);

  assign any_req_o = i_req_i | d_req_i;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr_q;
  logic rr_ptr_d;

  // Pointer toggles on every grant, whether or not there was contention.
  assign rr_ptr_d = grant_en_i ? ~rr_ptr_q : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= PORT_I;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    win_o = d_req_i ? PORT_D : PORT_I;
    if (i_req_i && d_req_i) begin
      win_o = rr_ptr_q;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, grant_en_i};

  always_comb begin
    win_o = d_req_i ? PORT_D : PORT_I;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one syncram port between fetch and data requesters
// Optional round-robin arbitration under MEM_ARB_RR_EN (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  arb_state_e        state_q;
  logic              owner_q;
  logic              write_q;
  logic              mem_cs_q;
  logic              mem_oe_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_din_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              i_ack_q;
  logic              d_ack_q;
  logic              busy_q;

  logic any_req;
  logic win;
  logic grant_en;
  logic rd_resp;

  assign grant_en = (state_q == IDLE) && any_req;

  mem_arb_pick u_pick (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_req_i    (i_req),
    .d_req_i    (d_req),
    .grant_en_i (grant_en),
    .any_req_o  (any_req),
    .win_o      (win)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= PORT_I;
      write_q    <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_oe_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_ack_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q  <= ACCESS;
            busy_q   <= 1'b1;
            owner_q  <= win;
            mem_cs_q <= 1'b1;
            if (win == PORT_D) begin
              mem_addr_q <= d_addr;
              mem_din_q  <= d_wdata;
              mem_we_q   <= d_we;
              mem_oe_q   <= ~d_we;
              write_q    <= d_we;
            end else begin
              mem_addr_q <= i_addr;
              mem_din_q  <= '0;
              mem_we_q   <= 1'b0;
              mem_oe_q   <= 1'b1;
              write_q    <= 1'b0;
            end
          end
        end
        ACCESS: begin
          state_q  <= RESP;
          mem_cs_q <= 1'b0;
          mem_oe_q <= 1'b0;
          mem_we_q <= 1'b0;
          if (owner_q == PORT_D) begin
            d_ack_q <= 1'b1;
          end else begin
            i_ack_q <= 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!write_q) begin
            if (owner_q == PORT_D) begin
              d_rdata_q <= mem_dout;
            end else begin
              i_rdata_q <= mem_dout;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // syncram dout only becomes valid in RESP, so the ack cycle forwards it
  // directly; the register takes over from the following cycle.
  assign rd_resp = (state_q == RESP) && !write_q;
  assign i_rdata = (rd_resp && owner_q == PORT_I) ? mem_dout : i_rdata_q;
  assign d_rdata = (rd_resp && owner_q == PORT_D) ? mem_dout : d_rdata_q;

  assign i_ack    = i_ack_q;
  assign d_ack    = d_ack_q;
  assign mem_cs   = mem_cs_q;
  assign mem_oe   = mem_oe_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
// Honours MEM_ARB_RR_EN to select the expected arbitration policy.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_cs;
  logic        mem_oe;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        busy;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_ack    (i_ack),
    .i_rdata  (i_rdata),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_ack    (d_ack),
    .d_rdata  (d_rdata),
    .mem_cs   (mem_cs),
    .mem_oe   (mem_oe),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .busy     (busy)
  );

`ifdef MEM_ARB_RR_EN
  localparam bit FIRST_D = 1'b0;
`else
  localparam bit FIRST_D = 1'b1;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [31:0] sram [0:31];
  logic [31:0] mmem [0:31];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_cs && mem_we) sram[mem_addr[6:2]] <= mem_din;
    if (mem_cs && mem_oe) mem_dout <= sram[mem_addr[6:2]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Transaction-level model: a grant in an idle cycle c means access in c+1,
  // ack in c+2, and the next grant no earlier than c+3.
  int          acc_c = -1;
  int          ack_c = -1;
  int          free_c = 0;
  bit          tx_port;
  bit          tx_we;
  logic [31:0] tx_addr;
  logic [31:0] tx_din;
  logic [31:0] tx_rd;
  logic [31:0] exp_i_rdata = '0;
  logic [31:0] exp_d_rdata = '0;
  bit          rr = 1'b0;
  bit          checking = 1'b0;
  bit          i_done = 1'b0;
  bit          d_done = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (cyc == acc_c) begin
        if (tx_we) mmem[tx_addr[6:2]] = tx_din;
        else tx_rd = mmem[tx_addr[6:2]];
      end
      if (cyc == ack_c) begin
        if (!tx_we) begin
          if (tx_port) exp_d_rdata = tx_rd;
          else exp_i_rdata = tx_rd;
        end
        if (tx_port) d_done = 1'b1;
        else i_done = 1'b1;
      end
      if (checking) begin
        chk("mem_cs", mem_cs, cyc == acc_c);
        chk("mem_oe", mem_oe, cyc == acc_c && !tx_we);
        chk("mem_we", mem_we, cyc == acc_c && tx_we);
        chk("busy", busy, cyc == acc_c || cyc == ack_c);
        chk("i_ack", i_ack, cyc == ack_c && !tx_port);
        chk("d_ack", d_ack, cyc == ack_c && tx_port);
        chk("i_rdata", i_rdata, exp_i_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        if (cyc == acc_c) begin
          chk("mem_addr", mem_addr, tx_addr);
          chk("mem_din", mem_din, tx_din);
        end
      end
      if (!rst_n) begin
        acc_c = -1;
        ack_c = -1;
        free_c = cyc + 1;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        rr = 1'b0;
        checking = 1'b1;
      end else if (cyc >= free_c && (i_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
        tx_port = (i_req && d_req) ? rr : d_req;
        rr = ~rr;
`else
        tx_port = d_req;
`endif
        tx_we   = tx_port ? d_we : 1'b0;
        tx_addr = tx_port ? d_addr : i_addr;
        tx_din  = tx_port ? d_wdata : 32'h0;
        acc_c   = cyc + 1;
        ack_c   = cyc + 2;
        free_c  = cyc + 3;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  bit i_pend, d_pend;
  int i_wait, d_wait, max_wait;

  task automatic new_i();
    i_pend = 1'b1;
    i_wait = 0;
    i_req  = 1'b1;
    i_addr = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
  endtask

  task automatic new_d();
    d_pend  = 1'b1;
    d_wait  = 0;
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(0, 1));
    d_addr  = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
    d_wdata = $urandom;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      sram[k] = (k == 1) ? 32'h8C22_0000 : (32'hA5A5_0000 | k);
      mmem[k] = sram[k];
    end
    mem_dout = '0;
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8; d_wdata = 32'h0;

    // Reset with both requests high, then contention on release.
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_cs", mem_cs, 0);
    chk("rst_acks", {i_ack, d_ack}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    rst_n = 1'b1;
    step();
    chk("first_grant_cs", mem_cs, 1);
    chk("first_grant_addr", mem_addr, FIRST_D ? 32'h8 : 32'h4);
    step();
    chk("contend_d_first", d_ack, FIRST_D);
    chk("contend_i_first", i_ack, !FIRST_D);
    chk("contend_i_rdata_1", i_rdata, FIRST_D ? 32'h0 : 32'h8C22_0000);
    step();
    if (FIRST_D) d_req = 1'b0; else i_req = 1'b0;
    step(); step();
    chk("contend_i_second", i_ack, FIRST_D);
    chk("contend_d_second", d_ack, !FIRST_D);
    chk("contend_i_rdata_2", i_rdata, 32'h8C22_0000);
    chk("contend_d_rdata_2", d_rdata, 32'hA5A5_0002);
    step();
    i_req = 1'b0; d_req = 1'b0;
    step(); step();

    // Single fetch.
    i_req = 1'b1; i_addr = 32'h4;
    step();
    chk("fetch_cs_oe", {mem_cs, mem_oe, mem_we}, 3'b110);
    step();
    chk("fetch_ack", i_ack, 1);
    chk("fetch_rdata", i_rdata, 32'h8C22_0000);
    i_req = 1'b0;
    step();
    chk("fetch_busy_low", busy, 0);
    step();

    // Write then read on the data port.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    step();
    chk("wr_we_high", mem_we, 1);
    step();
    chk("wr_ack", d_ack, 1);
    chk("wr_we_once", mem_we, 0);
    chk("wr_rdata_kept", d_rdata, 32'hA5A5_0002);
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b0;
    step(); step();
    chk("rd_ack", d_ack, 1);
    chk("rd_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 1'b0;
    step(); step();

    // Reset asserted during a read's access cycle.
    i_req = 1'b1; i_addr = 32'h8;
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_no_ack", i_ack, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cs", mem_cs, 0);
    chk("midrst_rdata", i_rdata, 0);
    rst_n = 1'b1; i_req = 1'b0;
    step(); step();

    // Randomized traffic from both protocol-following requesters.
    i_done = 1'b0; d_done = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0;
    max_wait = 0;
    repeat (1500) begin
      step();
      if (i_pend) i_wait++;
      if (d_pend) d_wait++;
      if (i_done) begin
        i_done = 1'b0; i_pend = 1'b0; i_req = 1'b0;
        if (i_wait > max_wait) max_wait = i_wait;
`ifdef MEM_ARB_RR_EN
        if ($urandom_range(0, 1) == 1) new_i();
`endif
      end else if (!i_pend && $urandom_range(0, 3) == 0) begin
        new_i();
      end
      if (d_done) begin
        d_done = 1'b0; d_pend = 1'b0; d_req = 1'b0;
        if (d_wait > max_wait) max_wait = d_wait;
`ifdef MEM_ARB_RR_EN
        if ($urandom_range(0, 1) == 1) new_d();
`endif
      end else if (!d_pend && $urandom_range(0, 2) == 0) begin
        new_d();
      end
      if (i_wait > 40 || d_wait > 40) begin
        $display("FAIL ack_timeout: i_wait %0d d_wait %0d limit 40", i_wait, d_wait);
        n_chk++;
        break;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (6) step();
    chk("max_wait_bound", max_wait <= 12, 1);
    chk("idle_at_end", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
